// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: funct3 encodings, LSU FSM states,
// byte-strobe constants and the access-legality rule.
package riscv_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    localparam logic [3:0] StrbNone = 4'b0000;
    localparam logic [3:0] StrbByte = 4'b0001;
    localparam logic [3:0] StrbHalf = 4'b0011;
    localparam logic [3:0] StrbWord = 4'b1111;

    // Exactly one of read/write, a funct3 legal for that direction, naturally aligned.
    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic f3_ok;
        logic aligned;
        if (wr) begin
            f3_ok = (f3 == Funct3B) || (f3 == Funct3H) || (f3 == Funct3W);
        end else begin
            f3_ok = f3 inside {Funct3B, Funct3H, Funct3W, Funct3Bu, Funct3Hu};
        end
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lo[0];
            2'b10:   aligned = (lo == 2'b00);
            default: aligned = 1'b0;
        endcase
        return (rd ^ wr) & f3_ok & aligned;
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Extracts the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to funct3.
module lsu_load_format
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            Funct3B:  result_o = {{24{byte_sel[7]}}, byte_sel};
            Funct3H:  result_o = {{16{half_sel[15]}}, half_sel};
            Funct3W:  result_o = rdata_i;
            Funct3Bu: result_o = {24'h0, byte_sel};
            Funct3Hu: result_o = {16'h0, half_sel};
            default:  result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_memstage.sv
// Memory-stage load/store unit: turns an EX/MEM access into a registered bus
// transaction, waits for ready or timeout, and formats the load result.
module lsu_memstage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alures_ex,
    input  logic [31:0] storedata_ex,
    input  logic        memread_ex,
    input  logic        memwrite_ex,
    input  logic [2:0]  funct3_ex,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        access_err,
    output logic        bus_timeout
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        stall_c;

    logic        access;
    logic        legal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] load_res;

    assign access = memread_ex | memwrite_ex;
    assign legal  = access_legal(memread_ex, memwrite_ex, funct3_ex, alures_ex[1:0]);

    always_comb begin
        case (funct3_ex[1:0])
            2'b00: begin
                st_wdata = {4{storedata_ex[7:0]}};
                st_wstrb = StrbByte << alures_ex[1:0];
            end
            2'b01: begin
                st_wdata = {2{storedata_ex[15:0]}};
                st_wstrb = StrbHalf << alures_ex[1:0];
            end
            default: begin
                st_wdata = storedata_ex;
                st_wstrb = StrbWord;
            end
        endcase
    end

    lsu_load_format u_load_format (
        .rdata_i  (mem_rdata),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .result_o (load_res)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            StIdle: begin
                if (legal) begin
                    state_d = StBusy;
                    req_d   = 1'b1;
                    we_d    = memwrite_ex;
                    addr_d  = {alures_ex[31:2], 2'b00};
                    wdata_d = st_wdata;
                    wstrb_d = memwrite_ex ? st_wstrb : StrbNone;
                    f3_d    = funct3_ex;
                    lane_d  = alures_ex[1:0];
                    cnt_d   = '0;
                    stall_c = 1'b1;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            StBusy: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // Ready takes priority over a timeout expiring in the same cycle.
                if (mem_ready) begin
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (!we_q) rd_d = load_res;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = StDone;
                    if (!we_q) rd_d = 32'h0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= StrbNone;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
            cnt_q   <= '0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign readdata    = rd_q;
    // Gated so an in-flight access releases the pipeline as soon as reset rises.
    assign stall       = stall_c & ~reset;
    assign access_err  = err_q;
    assign bus_timeout = tmo_q;

endmodule

// File: tb/tb_lsu_memstage.sv
// Scoreboard bench for lsu_memstage: a driver issues directed and random
// accesses, a responder models a variable-latency memory, a monitor checks.
module tb_lsu_memstage;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alures_ex, storedata_ex;
    logic        memread_ex, memwrite_ex;
    logic [2:0]  funct3_ex;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] readdata;
    logic        stall, access_err, bus_timeout;

    always #5 clk = ~clk;

    lsu_memstage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .alures_ex    (alures_ex),
        .storedata_ex (storedata_ex),
        .memread_ex   (memread_ex),
        .memwrite_ex  (memwrite_ex),
        .funct3_ex    (funct3_ex),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .readdata     (readdata),
        .stall        (stall),
        .access_err   (access_err),
        .bus_timeout  (bus_timeout)
    );

    typedef struct {
        bit          is_bus;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
        bit          tmo;
        int          nstall;
    } exp_t;

    exp_t        expq[$];
    int          lat_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] model_rd;
    bit          mon_en;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [1:0] lo);
        int size;
        if (rd == wr) return 0;
        if (wr && f3 > 3'd2) return 0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (int'(lo) % size) == 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] lane);
        logic [31:0] v;
        v = w >> (8 * int'(lane));
        case (f3)
            3'd0: begin v = v & 32'hff;   if (v >= 32'h80)   v = v | 32'hffffff00; end
            3'd4: v = v & 32'hff;
            3'd1: begin v = v & 32'hffff; if (v >= 32'h8000) v = v | 32'hffff0000; end
            3'd5: v = v & 32'hffff;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic drive_idle();
        memread_ex   = 1'b0;
        memwrite_ex  = 1'b0;
        funct3_ex    = 3'($urandom);
        alures_ex    = $urandom;
        storedata_ex = $urandom;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdat, input int lat);
        exp_t e;
        bit   done;
        int   lo;
        memread_ex   = rd;
        memwrite_ex  = wr;
        funct3_ex    = f3;
        alures_ex    = addr;
        storedata_ex = sd;
        lo = int'(addr[1:0]);
        if (!(rd || wr)) begin
            @(posedge clk); #1;
            drive_idle();
            return;
        end
        e = '{is_bus: 0, we: 0, addr: 0, wdata: 0, wstrb: 0, rd: model_rd, tmo: 0, nstall: 0};
        if (!model_legal(rd, wr, f3, addr[1:0])) begin
            expq.push_back(e);
            @(posedge clk); #1;
            drive_idle();
            return;
        end
        e.is_bus = 1;
        e.we     = wr;
        e.addr   = addr & 32'hffff_fffc;
        if (wr) begin
            case (f3)
                3'd0: begin e.wdata = (sd & 32'hff) * 32'h0101_0101;  e.wstrb = 4'(1 << lo); end
                3'd1: begin e.wdata = (sd & 32'hffff) * 32'h0001_0001; e.wstrb = 4'(3 << lo); end
                default: begin e.wdata = sd; e.wstrb = 4'hf; end
            endcase
        end
        e.tmo    = (lat >= int'(TIMEOUT));
        e.nstall = 1 + (e.tmo ? int'(TIMEOUT) : lat + 1);
        if (!wr) model_rd = e.tmo ? 32'h0 : load_model(rdat, f3, addr[1:0]);
        e.rd = model_rd;
        expq.push_back(e);
        lat_q.push_back(lat);
        dat_q.push_back(rdat);
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) begin done = 1; break; end
        end
        if (!done) chk("txn_release_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Memory model: asserts ready in BUSY cycle `lat`, random noise otherwise.
    initial begin
        bit          in_req;
        int          k, cur_lat;
        logic [31:0] cur_dat;
        in_req    = 0;
        k         = 0;
        cur_lat   = 0;
        cur_dat   = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!in_req) begin
                    in_req  = 1;
                    k       = 0;
                    cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
                    cur_dat = (dat_q.size() > 0) ? dat_q.pop_front() : 32'h0;
                end else begin
                    k++;
                end
                mem_ready = (k == cur_lat);
                mem_rdata = (k == cur_lat) ? cur_dat : $urandom;
            end else begin
                in_req    = 0;
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: compares DUT activity against the expectation queue.
    initial begin
        bit   prev_req, in_flight;
        int   nst;
        exp_t e;
        prev_req  = 0;
        in_flight = 0;
        nst       = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_req  = 0;
                in_flight = 0;
                continue;
            end
            if (access_err) begin
                if (expq.size() == 0) begin
                    chk("err_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("err_kind", 32'(e.is_bus), 32'd0);
                    chk("err_readdata", readdata, e.rd);
                    chk("err_no_req", 32'(mem_req), 32'd0);
                end
            end
            if (mem_req && !prev_req) begin
                if (expq.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expq[0];
                    chk("req_kind", 32'(e.is_bus), 32'd1);
                    chk("req_addr", mem_addr, e.addr);
                    chk("req_we", 32'(mem_we), 32'(e.we));
                    chk("req_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                    if (e.we) chk("req_wdata", mem_wdata, e.wdata);
                end
                in_flight = 1;
                nst = 1 + int'(stall);
            end else if (in_flight && mem_req) begin
                nst += int'(stall);
                chk("busy_timeout_low", 32'(bus_timeout), 32'd0);
            end else if (in_flight && !mem_req) begin
                in_flight = 0;
                if (expq.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("done_readdata", readdata, e.rd);
                    chk("done_timeout", 32'(bus_timeout), 32'(e.tmo));
                    chk("done_stall_low", 32'(stall), 32'd0);
                    chk("stall_cycles", 32'(nst), 32'(e.nstall));
                end
            end else begin
                chk("idle_stall", 32'(stall),
                    32'(model_legal(memread_ex, memwrite_ex, funct3_ex, alures_ex[1:0])));
                chk("idle_timeout_low", 32'(bus_timeout), 32'd0);
            end
            prev_req = mem_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit          rd, wr;
        int          op, lat, wait_n;
        logic [2:0]  f3;
        logic [31:0] a;
        n_chk    = 0;
        n_fail   = 0;
        mon_en   = 0;
        model_rd = 32'h0;
        reset    = 1'b1;
        drive_idle();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_err", 32'(access_err), 32'd0);
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1;
        @(posedge clk); #1;

        run_txn(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_txn(1, 0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0);
        run_txn(1, 0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1);
        run_txn(1, 0, 3'd1, 32'h102, 32'h0, 32'h80015A5A, 2);
        run_txn(0, 1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 0);
        run_txn(0, 1, 3'd1, 32'h202, 32'h00001234, 32'h0, 3);
        run_txn(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
        run_txn(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'd2, 32'h104, 32'h0, 32'h12345678, 40);
        run_txn(1, 0, 3'd2, 32'h108, 32'h0, 32'hCAFEF00D, int'(TIMEOUT) - 1);
        run_txn(0, 1, 3'd2, 32'h10C, 32'h55AA55AA, 32'h0, 40);

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            rd = (op <= 4) || (op == 9);
            wr = (op >= 5);
            if (op == 0) begin rd = 0; wr = 0; end
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) :
                 (rd && !wr) ? 3'($urandom_range(0, 2) + (($urandom_range(0, 1) == 1) ? 0 : 0)) :
                 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 3) == 0) f3 = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'd5;
            a   = 32'h0000_4000 + ($urandom & 32'h3ff);
            lat = ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) + 3 : int'($urandom_range(0, 5));
            run_txn(rd, wr, f3, a, $urandom, $urandom, lat);
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end

        // Reset while a load is outstanding in its fourth BUSY cycle.
        repeat (3) @(posedge clk);
        #1;
        mon_en = 0;
        memread_ex  = 1'b1;
        memwrite_ex = 1'b0;
        funct3_ex   = 3'd2;
        alures_ex   = 32'h300;
        lat_q.push_back(1000);
        dat_q.push_back(32'h0);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_req_high", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        drive_idle();
        lat_q.delete();
        dat_q.delete();
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        model_rd = 32'h0;
        mon_en   = 1;
        @(posedge clk); #1;
        run_txn(1, 0, 3'd2, 32'h100, 32'h0, 32'h0BADCAFE, 1);

        wait_n = 0;
        while (expq.size() != 0 && wait_n < 100) begin
            @(posedge clk);
            wait_n++;
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
